// File: rtl/smolboi_spi_pkg.sv
// Shared definitions for the SmolBoi SPI controller: FSM encoding and frame constants.
package smolboi_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_e;

  localparam int   FRAME_BITS = 16;
  localparam logic CMD_READ   = 1'b1;
  localparam logic CMD_WRITE  = 1'b0;

endpackage

// File: rtl/smolboi_spi_master_divider.sv
// Half-period divider for the SmolBoi SPI controller; emits rise_tick/fall_tick on the
// terminal count of each sclk half-period, phase restarts low on every clear.
module spi_sclk_divider #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             phase_r;
  logic             tick_s;

  assign tick_s    = en & (cnt_r == CNT_LAST);
  assign rise_tick = tick_s & ~phase_r;
  assign fall_tick = tick_s & phase_r;

  // Half-period counter and sclk phase tracker
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (clr) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (en) begin
      if (tick_s) begin
        cnt_r   <= '0;
        phase_r <= ~phase_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r   <= cnt_r;
      phase_r <= phase_r;
    end
  end

endmodule

// File: rtl/smolboi_spi_master.sv
// SmolBoi SPI controller (CPOL=0, CPHA=0, MSB first), 16-bit {addr, rw, data} frames.
// Optional build macro SMOLBOI_SPI_MISO_SYNC_EN adds a 2-flop synchronizer on miso.
module smolboi_spi_master
  import smolboi_spi_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int FW = ADDR_W + 1 + DATA_W;
  localparam int BW = $clog2(FW);

  spi_state_e        state_r;
  spi_state_e        state_nx_s;
  logic [FW-1:0]     frame_r;
  logic [FW-1:0]     frame_s;
  logic [BW-1:0]     bit_cnt_r;
  logic              rw_r;
  logic [DATA_W-1:0] cap_r;
  logic              accept_s;
  logic              active_nx_s;
  logic              div_en_s;
  logic              div_clr_s;
  logic              rise_tick_s;
  logic              fall_tick_s;
  logic              miso_s;

`ifdef SMOLBOI_SPI_MISO_SYNC_EN
  logic [1:0] miso_sync_r;

  // Two-flop synchronizer for an asynchronous miso pin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_sync_r <= 2'b00;
    end else begin
      miso_sync_r <= {miso_sync_r[0], miso};
    end
  end

  assign miso_s = miso_sync_r[1];
`else
  assign miso_s = miso;
`endif

  assign accept_s = start & ~busy;
  assign frame_s  = {addr, rw, (rw == CMD_READ) ? {DATA_W{1'b0}} : wdata};
  assign div_en_s = (state_r == ST_SETUP) | (state_r == ST_SHIFT) | (state_r == ST_HOLD);

  spi_sclk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (div_en_s),
    .clr       (div_clr_s),
    .rise_tick (rise_tick_s),
    .fall_tick (fall_tick_s)
  );

  // Next-state logic; the divider is cleared on each phase exit so every phase starts at count 0
  always_comb begin
    state_nx_s = state_r;
    div_clr_s  = ~div_en_s;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = ST_SETUP;
        else          state_nx_s = ST_IDLE;
      end
      ST_SETUP: begin
        if (rise_tick_s) begin
          state_nx_s = ST_SHIFT;
          div_clr_s  = 1'b1;
        end else begin
          state_nx_s = ST_SETUP;
        end
      end
      ST_SHIFT: begin
        if (fall_tick_s && (bit_cnt_r == '0)) begin
          state_nx_s = ST_HOLD;
          div_clr_s  = 1'b1;
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (rise_tick_s) begin
          state_nx_s = ST_DONE;
          div_clr_s  = 1'b1;
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      ST_DONE: begin
        if (accept_s) state_nx_s = ST_SETUP;
        else          state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  assign active_nx_s = (state_nx_s == ST_SETUP) | (state_nx_s == ST_SHIFT) |
                       (state_nx_s == ST_HOLD);

  // State register and registered handshake/chip-select outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      cs_n    <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy    <= active_nx_s;
      cs_n    <= ~active_nx_s;
      done    <= (state_nx_s == ST_DONE);
    end
  end

  // Frame shifter, sclk/mosi generation, miso capture and read result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_r   <= '0;
      bit_cnt_r <= '0;
      rw_r      <= CMD_WRITE;
      cap_r     <= '0;
      rdata     <= '0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      if (accept_s) begin
        rw_r      <= rw;
        frame_r   <= frame_s;
        bit_cnt_r <= BW'(FW - 1);
        mosi      <= frame_s[FW-1];
        sclk      <= 1'b0;
      end else if (state_r == ST_SHIFT) begin
        if (rise_tick_s) begin
          sclk <= 1'b1;
          // Only the data half of the frame carries peripheral read data
          if (bit_cnt_r < BW'(DATA_W)) begin
            cap_r <= {cap_r[DATA_W-2:0], miso_s};
          end
        end else if (fall_tick_s) begin
          sclk      <= 1'b0;
          bit_cnt_r <= bit_cnt_r - BW'(1);
          if (bit_cnt_r == '0) begin
            mosi <= 1'b0;
          end else begin
            frame_r <= {frame_r[FW-2:0], 1'b0};
            mosi    <= frame_r[FW-2];
          end
        end
      end
      if ((state_r == ST_HOLD) && rise_tick_s && (rw_r == CMD_READ)) begin
        rdata <= cap_r;
      end
    end
  end

endmodule
